// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ID->EX ALU-control stage.
// Decodes op/funct into ALU control codes and holds them in an EX pipeline
// register with hold/flush. Also tracks HI/LO multiply/divide occupancy with a
// latency counter and stalls ID while a HI/LO user would read a busy unit.
module alu_ctrl_stage #(
  parameter int CTRL_W  = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [5:0]        id_op_i,
  input  logic [5:0]        id_funct_i,
  input  logic              ex_hold_i,
  input  logic              flush_i,
  output logic              id_ready_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_alu_ctrl_o,
  output logic              ex_ri_o,
  output logic              hilo_busy_o
);

  // ALU control codes (5 bits wide, zero-extended to CTRL_W on the output).
  localparam logic [4:0] ALU_DEFAULT = 5'd0;
  localparam logic [4:0] ALU_AND     = 5'd1;
  localparam logic [4:0] ALU_OR      = 5'd2;
  localparam logic [4:0] ALU_XOR     = 5'd3;
  localparam logic [4:0] ALU_NOR     = 5'd4;
  localparam logic [4:0] ALU_SLL     = 5'd5;
  localparam logic [4:0] ALU_SRL     = 5'd6;
  localparam logic [4:0] ALU_SRA     = 5'd7;
  localparam logic [4:0] ALU_SLLV    = 5'd8;
  localparam logic [4:0] ALU_SRLV    = 5'd9;
  localparam logic [4:0] ALU_SRAV    = 5'd10;
  localparam logic [4:0] ALU_MFHI    = 5'd11;
  localparam logic [4:0] ALU_MFLO    = 5'd12;
  localparam logic [4:0] ALU_MTHI    = 5'd13;
  localparam logic [4:0] ALU_MTLO    = 5'd14;
  localparam logic [4:0] ALU_ADD     = 5'd15;
  localparam logic [4:0] ALU_ADDU    = 5'd16;
  localparam logic [4:0] ALU_SUB     = 5'd17;
  localparam logic [4:0] ALU_SUBU    = 5'd18;
  localparam logic [4:0] ALU_SLT     = 5'd19;
  localparam logic [4:0] ALU_SLTU    = 5'd20;
  localparam logic [4:0] ALU_MULT    = 5'd21;
  localparam logic [4:0] ALU_MULTU   = 5'd22;
  localparam logic [4:0] ALU_DIV     = 5'd23;
  localparam logic [4:0] ALU_DIVU    = 5'd24;
  localparam logic [4:0] ALU_LUI     = 5'd25;

  localparam logic [7:0] MUL_LAT_C = 8'(MUL_LAT);
  localparam logic [7:0] DIV_LAT_C = 8'(DIV_LAT);

  // Zero-extend a 5-bit ALU code to the output width.
  function automatic logic [CTRL_W-1:0] ext_code(input logic [4:0] code);
    logic [CTRL_W-1:0] res;
    res      = {CTRL_W{1'b0}};
    res[4:0] = code;
    return res;
  endfunction

  logic [4:0]        code_s;
  logic              ri_s;
  logic              uses_hilo_s;
  logic              is_mul_s;
  logic              is_div_s;
  logic              hazard_s;
  logic              ready_s;
  logic              accept_s;
  logic              ex_valid_nxt_s;
  logic [CTRL_W-1:0] ex_ctrl_nxt_s;
  logic              ex_ri_nxt_s;
  logic [7:0]        cnt_nxt_s;

  logic              ex_valid_r;
  logic [CTRL_W-1:0] ex_ctrl_r;
  logic              ex_ri_r;
  logic [7:0]        cnt_r;
  logic              hilo_busy_r;

  // Decode op/funct into an ALU code; anything unlisted is reserved.
  always_comb begin
    code_s = ALU_DEFAULT;
    ri_s   = 1'b0;
    case (id_op_i)
      6'h00: begin
        case (id_funct_i)
          6'h00:   code_s = ALU_SLL;
          6'h02:   code_s = ALU_SRL;
          6'h03:   code_s = ALU_SRA;
          6'h04:   code_s = ALU_SLLV;
          6'h06:   code_s = ALU_SRLV;
          6'h07:   code_s = ALU_SRAV;
          6'h10:   code_s = ALU_MFHI;
          6'h11:   code_s = ALU_MTHI;
          6'h12:   code_s = ALU_MFLO;
          6'h13:   code_s = ALU_MTLO;
          6'h18:   code_s = ALU_MULT;
          6'h19:   code_s = ALU_MULTU;
          6'h1A:   code_s = ALU_DIV;
          6'h1B:   code_s = ALU_DIVU;
          6'h20:   code_s = ALU_ADD;
          6'h21:   code_s = ALU_ADDU;
          6'h22:   code_s = ALU_SUB;
          6'h23:   code_s = ALU_SUBU;
          6'h24:   code_s = ALU_AND;
          6'h25:   code_s = ALU_OR;
          6'h26:   code_s = ALU_XOR;
          6'h27:   code_s = ALU_NOR;
          6'h2A:   code_s = ALU_SLT;
          6'h2B:   code_s = ALU_SLTU;
          default: begin
            code_s = ALU_DEFAULT;
            ri_s   = 1'b1;
          end
        endcase
      end
      6'h08:   code_s = ALU_ADD;
      6'h09:   code_s = ALU_ADDU;
      6'h0A:   code_s = ALU_SLT;
      6'h0B:   code_s = ALU_SLTU;
      6'h0C:   code_s = ALU_AND;
      6'h0D:   code_s = ALU_OR;
      6'h0E:   code_s = ALU_XOR;
      6'h0F:   code_s = ALU_LUI;
      default: begin
        code_s = ALU_DEFAULT;
        ri_s   = 1'b1;
      end
    endcase
  end

  // Classify the decoded code for HI/LO interlock and counter loading.
  always_comb begin
    uses_hilo_s = 1'b0;
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    case (code_s)
      ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO: uses_hilo_s = 1'b1;
      ALU_MULT, ALU_MULTU: begin
        uses_hilo_s = 1'b1;
        is_mul_s    = 1'b1;
      end
      ALU_DIV, ALU_DIVU: begin
        uses_hilo_s = 1'b1;
        is_div_s    = 1'b1;
      end
      default: uses_hilo_s = 1'b0;
    endcase
  end

  // Handshake: stall ID on downstream hold or on a HI/LO hazard.
  always_comb begin
    hazard_s = id_valid_i & uses_hilo_s & hilo_busy_r;
    ready_s  = ~ex_hold_i & ~hazard_s;
    accept_s = id_valid_i & ready_s & ~flush_i;
  end

  // Next EX register contents: hold beats flush beats bubble beats load.
  always_comb begin
    ex_valid_nxt_s = ex_valid_r;
    ex_ctrl_nxt_s  = ex_ctrl_r;
    ex_ri_nxt_s    = ex_ri_r;
    if (ex_hold_i) begin
      ex_valid_nxt_s = ex_valid_r;
      ex_ctrl_nxt_s  = ex_ctrl_r;
      ex_ri_nxt_s    = ex_ri_r;
    end else if (flush_i || hazard_s || !id_valid_i) begin
      ex_valid_nxt_s = 1'b0;
      ex_ctrl_nxt_s  = ext_code(ALU_DEFAULT);
      ex_ri_nxt_s    = 1'b0;
    end else begin
      ex_valid_nxt_s = 1'b1;
      ex_ctrl_nxt_s  = ext_code(code_s);
      ex_ri_nxt_s    = ri_s;
    end
  end

  // Busy counter: load on an accepted MULT/DIV, otherwise count down to zero.
  // It ignores hold and flush so an op already in flight always completes.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (accept_s && is_mul_s) begin
      cnt_nxt_s = MUL_LAT_C;
    end else if (accept_s && is_div_s) begin
      cnt_nxt_s = DIV_LAT_C;
    end else if (cnt_r != 8'd0) begin
      cnt_nxt_s = cnt_r - 8'd1;
    end else begin
      cnt_nxt_s = 8'd0;
    end
  end

  // EX pipeline register and busy counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r  <= 1'b0;
      ex_ctrl_r   <= ext_code(ALU_DEFAULT);
      ex_ri_r     <= 1'b0;
      cnt_r       <= 8'd0;
      hilo_busy_r <= 1'b0;
    end else begin
      ex_valid_r  <= ex_valid_nxt_s;
      ex_ctrl_r   <= ex_ctrl_nxt_s;
      ex_ri_r     <= ex_ri_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hilo_busy_r <= (cnt_nxt_s != 8'd0);
    end
  end

  assign id_ready_o    = ready_s;
  assign ex_valid_o    = ex_valid_r;
  assign ex_alu_ctrl_o = ex_ctrl_r;
  assign ex_ri_o       = ex_ri_r;
  assign hilo_busy_o   = hilo_busy_r;

endmodule
